fetch_decode_pipe: RTL and testbench

- Registered, back-pressurable fetch-decode stage for the core.
- Generates sequential PCs and issues instruction-memory requests with a bounded number outstanding.
- Buffers returned instructions in a parametrised prefetch FIFO, then decodes the FIFO head into immediate, ALU op and control bits.
- Presents the decoded result to execute through a valid/ready output register; a redirect from execute flushes all in-flight state.

---
 rtl/fetch_decode_pipe_pkg.sv | 67 ++++++
 rtl/instr_fifo.sv | 71 +++++++
 rtl/fetch_decode_pipe.sv | 188 ++++++++++++++++++
 tb/tb_fetch_decode_pipe.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_pipe_pkg.sv
// rtl/fetch_decode_pipe_pkg.sv - opcode, ALU op and control encodings shared by the fetch-decode stage
package fetch_decode_pipe_pkg;

    localparam int ID_CTRL_W = 7;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_I_ARITH = 7'b0010011;
    localparam logic [6:0] OPC_R_ARITH = 7'b0110011;

    localparam logic [3:0] ALU_OP_ADD   = 4'd0;
    localparam logic [3:0] ALU_OP_SUB   = 4'd1;
    localparam logic [3:0] ALU_OP_SLL   = 4'd2;
    localparam logic [3:0] ALU_OP_SLT   = 4'd3;
    localparam logic [3:0] ALU_OP_SLTU  = 4'd4;
    localparam logic [3:0] ALU_OP_XOR   = 4'd5;
    localparam logic [3:0] ALU_OP_SRL   = 4'd6;
    localparam logic [3:0] ALU_OP_SRA   = 4'd7;
    localparam logic [3:0] ALU_OP_OR    = 4'd8;
    localparam logic [3:0] ALU_OP_AND   = 4'd9;
    localparam logic [3:0] ALU_OP_PASSB = 4'd10;

    // {exec_a (pc operand), exec_b (imm operand), mem_w, reg_w, mem2reg, bra, jmp}
    localparam logic [ID_CTRL_W-1:0] LUI_CTRL     = 7'b0101000;
    localparam logic [ID_CTRL_W-1:0] AUIPC_CTRL   = 7'b1101000;
    localparam logic [ID_CTRL_W-1:0] JAL_CTRL     = 7'b1101001;
    localparam logic [ID_CTRL_W-1:0] JALR_CTRL    = 7'b0101001;
    localparam logic [ID_CTRL_W-1:0] BRANCH_CTRL  = 7'b0000010;
    localparam logic [ID_CTRL_W-1:0] LOAD_CTRL    = 7'b0101100;
    localparam logic [ID_CTRL_W-1:0] STORE_CTRL   = 7'b0110000;
    localparam logic [ID_CTRL_W-1:0] I_ARITH_CTRL = 7'b0101000;
    localparam logic [ID_CTRL_W-1:0] R_ARITH_CTRL = 7'b0001000;

    typedef struct packed {
        logic [31:0]          imm;
        logic [3:0]           alu_op;
        logic [ID_CTRL_W-1:0] ctrl;
        logic                 illegal;
    } dec_t;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

    function automatic logic [2:0] funct3_of(input logic [31:0] instr);
        return instr[14:12];
    endfunction

    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_OP_SUB : ALU_OP_ADD;
            3'b001:  return ALU_OP_SLL;
            3'b010:  return ALU_OP_SLT;
            3'b011:  return ALU_OP_SLTU;
            3'b100:  return ALU_OP_XOR;
            3'b101:  return alt ? ALU_OP_SRA : ALU_OP_SRL;
            3'b110:  return ALU_OP_OR;
            default: return ALU_OP_AND;
        endcase
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - synchronous prefetch FIFO; clear wins over push and pop
module instr_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        // a pop at empty is ignored, so push+pop at empty stores without bypass
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_COUNT) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);

endmodule

// File: rtl/fetch_decode_pipe.sv
// rtl/fetch_decode_pipe.sv - credit-limited instruction fetch, prefetch FIFO and registered decode
module fetch_decode_pipe #(
    parameter logic [31:0] PC_RESET        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_imm,
    output logic [3:0]  id_aluOp,
    output logic [6:0]  id_ctrl,
    output logic        id_illegal
);
    import fetch_decode_pipe_pkg::*;

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]          fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [OW-1:0]        out_q, out_d, discard_q, discard_d;
    logic                 req_en_q, req_en_d;
    logic                 id_valid_q, id_valid_d, id_illegal_q, id_illegal_d;
    logic [31:0]          id_pc_q, id_pc_d, id_instr_q, id_instr_d, id_imm_q, id_imm_d;
    logic [3:0]           id_alu_op_q, id_alu_op_d;
    logic [ID_CTRL_W-1:0] id_ctrl_q, id_ctrl_d;

    logic          accept, keep_rsp, load;
    logic [63:0]   fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty, fifo_full;
    logic [31:0]   head;
    dec_t          dec;

    instr_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (keep_rsp),
        .pop   (load),
        .clear (redirect_valid),
        .din   ({rsp_pc_q, imem_rdata}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        // req_en_q keeps the request low for the first cycle after reset
        imem_req  = req_en_q && !redirect_valid && !fifo_full
                    && (int'(out_q) + int'(fifo_count) < FIFO_DEPTH)
                    && (int'(out_q) < MAX_OUTSTANDING);
        imem_addr = fetch_pc_q;
        accept    = imem_req && imem_gnt;
        keep_rsp  = imem_rvalid && (discard_q == '0) && !redirect_valid;
        load      = !fifo_empty && (!id_valid_q || id_ready) && !redirect_valid;
        req_en_d  = 1'b1;

        out_d      = out_q + OW'(accept) - OW'(imem_rvalid);
        fetch_pc_d = accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
        rsp_pc_d   = keep_rsp ? rsp_pc_q + 32'd4 : rsp_pc_q;
        discard_d  = (imem_rvalid && discard_q != '0) ? discard_q - OW'(1) : discard_q;
        if (redirect_valid) begin
            // every request still in flight, including pending discards, must be dropped
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            discard_d  = out_q - OW'(imem_rvalid);
        end
    end

    always_comb begin
        head = fifo_dout[31:0];
        dec  = '0;
        case (opcode_of(head))
            OPC_LUI: begin
                dec.imm = {head[31:12], 12'b0};  dec.alu_op = ALU_OP_PASSB; dec.ctrl = LUI_CTRL;
            end
            OPC_AUIPC: begin
                dec.imm = {head[31:12], 12'b0};  dec.alu_op = ALU_OP_ADD;   dec.ctrl = AUIPC_CTRL;
            end
            OPC_JAL: begin
                dec.imm  = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
                dec.ctrl = JAL_CTRL;
            end
            OPC_JALR: begin
                dec.imm = {{20{head[31]}}, head[31:20]}; dec.ctrl = JALR_CTRL;
            end
            OPC_BRANCH: begin
                dec.imm    = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
                dec.alu_op = ALU_OP_SUB;
                dec.ctrl   = BRANCH_CTRL;
            end
            OPC_LOAD: begin
                dec.imm = {{20{head[31]}}, head[31:20]}; dec.ctrl = LOAD_CTRL;
            end
            OPC_STORE: begin
                dec.imm = {{20{head[31]}}, head[31:25], head[11:7]}; dec.ctrl = STORE_CTRL;
            end
            OPC_I_ARITH: begin
                dec.ctrl = I_ARITH_CTRL;
                if (funct3_of(head) == 3'b001 || funct3_of(head) == 3'b101) begin
                    dec.imm    = {27'b0, head[24:20]};
                    dec.alu_op = alu_from_funct3(funct3_of(head), head[30]);
                end else begin
                    dec.imm    = {{20{head[31]}}, head[31:20]};
                    dec.alu_op = alu_from_funct3(funct3_of(head), 1'b0);
                end
            end
            OPC_R_ARITH: begin
                dec.alu_op = alu_from_funct3(funct3_of(head), head[30]);
                dec.ctrl   = R_ARITH_CTRL;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    always_comb begin
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        id_imm_d     = id_imm_q;
        id_alu_op_d  = id_alu_op_q;
        id_ctrl_d    = id_ctrl_q;
        id_illegal_d = id_illegal_q;
        if (redirect_valid) begin
            id_valid_d = 1'b0;
        end else if (load) begin
            id_valid_d   = 1'b1;
            id_pc_d      = fifo_dout[63:32];
            id_instr_d   = head;
            id_imm_d     = dec.imm;
            id_alu_op_d  = dec.alu_op;
            id_ctrl_d    = dec.ctrl;
            id_illegal_d = dec.illegal;
        end else if (id_valid_q && id_ready) begin
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q   <= PC_RESET;
            rsp_pc_q     <= PC_RESET;
            out_q        <= '0;
            discard_q    <= '0;
            req_en_q     <= 1'b0;
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            id_instr_q   <= '0;
            id_imm_q     <= '0;
            id_alu_op_q  <= '0;
            id_ctrl_q    <= '0;
            id_illegal_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            rsp_pc_q     <= rsp_pc_d;
            out_q        <= out_d;
            discard_q    <= discard_d;
            req_en_q     <= req_en_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            id_imm_q     <= id_imm_d;
            id_alu_op_q  <= id_alu_op_d;
            id_ctrl_q    <= id_ctrl_d;
            id_illegal_q <= id_illegal_d;
        end
    end

    assign id_valid   = id_valid_q;
    assign id_pc      = id_pc_q;
    assign id_instr   = id_instr_q;
    assign id_imm     = id_imm_q;
    assign id_aluOp   = id_alu_op_q;
    assign id_ctrl    = id_ctrl_q;
    assign id_illegal = id_illegal_q;

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// tb/tb_fetch_decode_pipe.sv - directed bench for fetch_decode_pipe with an in-order imem model
module tb_fetch_decode_pipe;

    logic        clk = 1'b0;
    logic        rst, imem_req, imem_gnt, imem_rvalid, redirect_valid;
    logic        id_valid, id_ready, id_illegal;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, id_pc, id_instr, id_imm;
    logic [3:0]  id_alu_op;
    logic [6:0]  id_ctrl;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int first_gnt_cyc = -1;
    int dec_seen = 0;
    int hs_count = 0;
    logic [31:0] exp_pc;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t       pend[$];
    logic [31:0] gnt_log[$];

    fetch_decode_pipe #(
        .PC_RESET        (32'h0000_0000),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_imm         (id_imm),
        .id_aluOp       (id_alu_op),
        .id_ctrl        (id_ctrl),
        .id_illegal     (id_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        case (a)
            32'h200: return 32'hFE010113;
            32'h204: return 32'h00A12223;
            32'h208: return 32'hFE000EE3;
            32'h20C: return 32'h000122B7;
            32'h210: return 32'h0000007F;
            32'h214: return 32'h40515293;
            32'h218: return 32'h008000EF;
            32'h21C: return 32'h40208033;
            default: return {a[11:0], 20'h00013};
        endcase
    endfunction

    function automatic logic [31:0] exp_imm(input logic [31:0] a);
        case (a)
            32'h200: return 32'hFFFFFFE0;
            32'h204: return 32'h00000004;
            32'h208: return 32'hFFFFFFFC;
            32'h20C: return 32'h00012000;
            32'h210: return 32'h00000000;
            32'h214: return 32'h00000005;
            32'h218: return 32'h00000008;
            32'h21C: return 32'h00000000;
            default: return {{20{a[11]}}, a[11:0]};
        endcase
    endfunction

    // {alu_op, ctrl, illegal}
    function automatic logic [11:0] exp_bits(input logic [31:0] a);
        case (a)
            32'h200: return {4'd0,  7'b0101000, 1'b0};
            32'h204: return {4'd0,  7'b0110000, 1'b0};
            32'h208: return {4'd1,  7'b0000010, 1'b0};
            32'h20C: return {4'd10, 7'b0101000, 1'b0};
            32'h210: return {4'd0,  7'b0000000, 1'b1};
            32'h214: return {4'd7,  7'b0101000, 1'b0};
            32'h218: return {4'd0,  7'b1101001, 1'b0};
            32'h21C: return {4'd1,  7'b0001000, 1'b0};
            default: return {4'd0,  7'b0101000, 1'b0};
        endcase
    endfunction

    task automatic wait_id_valid(input string tag, input int max);
        int n = 0;
        while (!id_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(id_valid), 32'd1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
            if (rst) begin
                pend.delete();
            end else begin
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = instr_at(pend[0].addr);
                    void'(pend.pop_front());
                end
                if (imem_req) begin
                    imem_gnt = 1'b1;
                    pend.push_back('{imem_addr, cyc + lat});
                    gnt_log.push_back(imem_addr);
                    if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !redirect_valid && id_valid && id_ready) begin
                check("hs_pc", id_pc, exp_pc);
                check("hs_instr", id_instr, instr_at(exp_pc));
                check("hs_imm", id_imm, exp_imm(exp_pc));
                check("hs_dec", {20'b0, id_alu_op, id_ctrl, id_illegal}, {20'b0, exp_bits(exp_pc)});
                if (exp_pc >= 32'h200 && exp_pc < 32'h220) dec_seen++;
                hs_count++;
                exp_pc = exp_pc + 32'd4;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int          n;
        int          hs0;
        logic [31:0] hold_pc, hold_instr;

        rst            = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        exp_pc         = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_instr", id_instr, 32'd0);
        check("rst_id_ctrl", 32'(id_ctrl), 32'd0);
        gnt_log.delete();
        first_gnt_cyc = -1;
        rst = 1'b0;
        check("post_rst_req", 32'(imem_req), 32'd0);

        wait_id_valid("first", 20);
        check("first_latency", 32'(cyc - first_gnt_cyc), 32'd3);
        check("gnt_log_size", 32'(gnt_log.size()), 32'd3);
        check("addr0", gnt_log[0], 32'h0);
        check("addr1", gnt_log[1], 32'h4);
        check("addr2", gnt_log[2], 32'h8);
        repeat (8) begin
            @(negedge clk);
            check("thru_valid", 32'(id_valid), 32'd1);
        end

        id_ready   = 1'b0;
        hold_pc    = id_pc;
        hold_instr = id_instr;
        repeat (10) begin
            @(negedge clk);
            check("stall_valid", 32'(id_valid), 32'd1);
            check("stall_pc", id_pc, hold_pc);
            check("stall_instr", id_instr, hold_instr);
        end
        check("stall_req", 32'(imem_req), 32'd0);
        id_ready = 1'b1;
        repeat (6) @(negedge clk);

        lat = 3;
        n = 0;
        while (!(pend.size() == 2 && pend[0].due > cyc) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("redir1_pending", 32'(pend.size()), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        exp_pc         = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_id_valid("redir1", 40);
        check("redir1_pc", id_pc, 32'h100);
        check("redir1_instr", id_instr, instr_at(32'h100));
        repeat (4) @(negedge clk);

        n = 0;
        while (!(pend.size() > 0 && pend[0].due <= cyc) && n < 40) begin
            @(negedge clk);
            n++;
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        exp_pc         = 32'h300;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_id_valid("redir2", 40);
        check("redir2_pc", id_pc, 32'h300);
        check("redir2_instr", id_instr, instr_at(32'h300));
        hs0 = hs_count;
        repeat (12) @(negedge clk);
        check("redir2_flow", 32'((hs_count - hs0) >= 4), 32'd1);

        lat = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        exp_pc         = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("dec_seen", 32'(dec_seen), 32'd8);

        id_ready = 1'b0;
        repeat (10) @(negedge clk);
        check("full_req", 32'(imem_req), 32'd0);
        rst    = 1'b1;
        exp_pc = 32'h0;
        @(negedge clk);
        check("rst2_id_valid", 32'(id_valid), 32'd0);
        check("rst2_imem_req", 32'(imem_req), 32'd0);
        rst = 1'b0;
        gnt_log.delete();
        id_ready = 1'b1;
        wait_id_valid("rst2", 20);
        check("rst2_id_pc", id_pc, 32'h0);
        check("rst2_first_addr", gnt_log[0], 32'h0);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
